// File: rtl/mul_ctrl.sv
// mul_ctrl: EX-stage multiply sequencer; feeds magnitudes to a fixed-latency unsigned core,
// then sign-corrects, accumulates into HI/LO and holds the result until write-back drains.
module mul_ctrl #(
    parameter int LATENCY = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        flush,
    input  logic        mem_stall,
    output logic        stall_ex,
    output logic        res_valid,
    output logic        wr_hilo,
    output logic        wr_gpr,
    output logic [63:0] res_hilo,
    output logic [31:0] res_gpr,
    output logic        mul_ce,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p
);
    localparam int CW = $clog2(LATENCY + 1);
    typedef enum logic [1:0] {IDLE, BUSY, ACC, DONE} state_t;
    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]  op_q;
    logic        neg_q;
    logic [63:0] hilo_q;
    logic        mul_ce_q;
    logic        res_valid_q;
    logic        wr_hilo_q;
    logic        wr_gpr_q;
    logic [31:0] mul_a_q;
    logic [31:0] mul_b_q;
    logic [63:0] res_hilo_q;
    logic [31:0] res_gpr_q;
    logic        sgn;
    logic        accept;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] prod;
    logic [63:0] acc_res;
    // Even op codes are the signed variants.
    assign sgn     = ~op_code[0];
    assign accept  = state_q == IDLE && op_valid && !flush && op_code != 3'b111;
    assign mag_a   = (sgn && src_a[31]) ? ~src_a + 32'd1 : src_a;
    assign mag_b   = (sgn && src_b[31]) ? ~src_b + 32'd1 : src_b;
    assign prod    = neg_q ? ~mul_p + 64'd1 : mul_p;
    assign acc_res = op_q[2:1] == 2'b01 ? hilo_q + prod :
                     op_q[2:1] == 2'b10 ? hilo_q - prod : prod;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            hilo_q      <= '0;
            mul_ce_q    <= 1'b0;
            res_valid_q <= 1'b0;
            wr_hilo_q   <= 1'b0;
            wr_gpr_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_hilo_q  <= '0;
            res_gpr_q   <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_ce_q    <= 1'b0;
            res_valid_q <= 1'b0;
            wr_hilo_q   <= 1'b0;
            wr_gpr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_q  <= BUSY;
                    cnt_q    <= '0;
                    op_q     <= op_code;
                    neg_q    <= sgn & (src_a[31] ^ src_b[31]);
                    hilo_q   <= {hi_in, lo_in};
                    mul_a_q  <= mag_a;
                    mul_b_q  <= mag_b;
                    mul_ce_q <= 1'b1;
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(LATENCY - 1)) begin
                        state_q  <= ACC;
                        mul_ce_q <= 1'b0;
                    end
                end
                ACC: begin
                    state_q     <= DONE;
                    res_hilo_q  <= acc_res;
                    res_gpr_q   <= prod[31:0];
                    res_valid_q <= 1'b1;
                    wr_gpr_q    <= op_q == 3'b110;
                    wr_hilo_q   <= op_q != 3'b110;
                end
                default: if (!mem_stall) begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                    wr_hilo_q   <= 1'b0;
                    wr_gpr_q    <= 1'b0;
                end
            endcase
        end
    end
    // A flush in DONE must suppress the commit in that same cycle.
    assign res_valid = res_valid_q & ~flush;
    assign wr_hilo   = wr_hilo_q & ~flush;
    assign wr_gpr    = wr_gpr_q & ~flush;
    assign stall_ex  = ~flush & (accept | state_q == BUSY | state_q == ACC);
    assign mul_ce    = mul_ce_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_hilo  = res_hilo_q;
    assign res_gpr   = res_gpr_q;
endmodule
